// File: rtl/image_avg_pkg.sv
// Shared types and constants for the image averaging divider.
// ROUND_NEAREST_EN widens the divide by one bit to hold the rounding bias.
package image_avg_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int SUM_W      = 24;
  localparam int CNT_W      = 14;
  localparam int PIX_W      = 8;
  localparam int PIX_CNT_W  = $clog2(NUM_PIXELS);

`ifdef ROUND_NEAREST_EN
  localparam int DIV_W = SUM_W + 1;
`else
  localparam int DIV_W = SUM_W;
`endif

  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [DIV_W-1:0] div_t;

  localparam pix_t PIX_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    HOLD,
    DONE
  } avg_state_e;

endpackage

// File: rtl/image_average_divider_serial_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, MSB first.
// valid pulses for one cycle when quotient holds the final result.
module serial_divider #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic                  valid
);

  localparam int STEP_W = $clog2(DIVIDEND_W + 1);

  logic                  running_q, running_d;
  logic                  valid_q, valid_d;
  logic [STEP_W-1:0]     count_q, count_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [DIVIDEND_W-1:0] work_q, work_d;

  logic [DIVISOR_W:0]    rem_shift;
  logic [DIVISOR_W-1:0]  rem_diff;
  logic                  fits;

  // work_q shifts dividend bits out at the top and quotient bits in at the bottom.
  assign rem_shift = {rem_q, work_q[DIVIDEND_W-1]};
  assign fits      = rem_shift >= {1'b0, divisor_q};
  assign rem_diff  = rem_shift[DIVISOR_W-1:0] - divisor_q;

  always_comb begin
    running_d = running_q;
    valid_d   = 1'b0;
    count_d   = count_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    work_d    = work_q;
    if (start) begin
      running_d = 1'b1;
      count_d   = STEP_W'(DIVIDEND_W);
      rem_d     = '0;
      divisor_d = divisor;
      work_d    = dividend;
    end else if (running_q) begin
      rem_d   = fits ? rem_diff : rem_shift[DIVISOR_W-1:0];
      work_d  = {work_q[DIVIDEND_W-2:0], fits};
      count_d = count_q - STEP_W'(1);
      if (count_q == STEP_W'(1)) begin
        running_d = 1'b0;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_q <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      work_q    <= '0;
    end else begin
      running_q <= running_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      work_q    <= work_d;
    end
  end

  assign quotient = work_q;
  assign valid    = valid_q;

endmodule

// File: rtl/image_average_divider.sv
// Streams per-pixel sums through one shared serial divider to produce averaged pixels.
// Define ROUND_NEAREST_EN for round-half-up instead of floor division.
module image_average_divider
  import image_avg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_images,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             sat
);

  avg_state_e           state_q, state_d;
  cnt_t                 divisor_q, divisor_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  pix_t                 out_pix_q, out_pix_d;
  logic                 div_zero_q, div_zero_d;
  logic                 sat_q, sat_d;

  logic div_start;
  logic div_valid;
  div_t dividend;
  div_t quotient;

`ifdef ROUND_NEAREST_EN
  // Bias by half the divisor in the widened dividend so the sum cannot overflow.
  assign dividend = {1'b0, in_sum} + DIV_W'(divisor_q >> 1);
`else
  assign dividend = in_sum;
`endif

  serial_divider #(
    .DIVIDEND_W (DIV_W),
    .DIVISOR_W  (CNT_W)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor_q),
    .quotient (quotient),
    .valid    (div_valid)
  );

  always_comb begin
    state_d    = state_q;
    divisor_d  = divisor_q;
    pix_cnt_d  = pix_cnt_q;
    out_pix_d  = out_pix_q;
    div_zero_d = div_zero_q;
    sat_d      = sat_q;
    div_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d  = num_images;
          pix_cnt_d  = '0;
          div_zero_d = 1'b0;
          sat_d      = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (divisor_q == '0) begin
            out_pix_d  = '0;
            div_zero_d = 1'b1;
            state_d    = HOLD;
          end else begin
            div_start = 1'b1;
            state_d   = DIV;
          end
        end
      end
      DIV: begin
        if (div_valid) begin
          if (quotient > DIV_W'(PIX_MAX)) begin
            out_pix_d = PIX_MAX;
            sat_d     = 1'b1;
          end else begin
            out_pix_d = quotient[PIX_W-1:0];
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
          state_d   = (pix_cnt_q == PIX_CNT_W'(NUM_PIXELS - 1)) ? DONE : LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      divisor_q  <= '0;
      pix_cnt_q  <= '0;
      out_pix_q  <= '0;
      div_zero_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      divisor_q  <= divisor_d;
      pix_cnt_q  <= pix_cnt_d;
      out_pix_q  <= out_pix_d;
      div_zero_q <= div_zero_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_pix   = out_pix_q;
  assign div_zero  = div_zero_q;
  assign sat       = sat_q;

endmodule
